seq_blocks_0_result_sink: RTL and testbench
===========================================

SEQ_BLOCKS_0_RESULT_SINK -- requirements
Module: seq_blocks_0_result_sink

Interface
REQ-001 SHALL have parameter IN_SIZE, default 32: elements per beat.
REQ-002 SHALL have parameter IN_WIDTH, default 16: bits per element.
REQ-003 SHALL have parameter IN_DEPTH, default 8: beats per frame, equal to the RAM depth.
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(IN_DEPTH)+1: read address width.
REQ-005 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port data_in, input, IN_SIZE x IN_WIDTH unpacked array: incoming beat.
REQ-008 SHALL have port data_in_valid, input, 1: beat present.
REQ-009 SHALL have port data_in_ready, output, 1: sink accepts a beat.
REQ-010 SHALL have port clear, input, 1: discard frame and re-arm capture.
REQ-011 SHALL have port address0, input, ADDR_WIDTH: read address.
REQ-012 SHALL have port ce0, input, 1: read pipeline enable.
REQ-013 SHALL have port q0, output, IN_WIDTH*IN_SIZE: read data.
REQ-014 SHALL have port done, output, 1: full frame captured.
REQ-015 SHALL have port count, output, ADDR_WIDTH: beats accepted in the current frame.

Function
REQ-016 SHALL use a two-state FSM: FILL (capturing) and FULL (frame held).
REQ-017 SHALL drive data_in_ready = 1 exactly when state is FILL; it is a state decode and does not depend on data_in_valid.
REQ-018 SHALL accept a beat only on a cycle with data_in_valid && data_in_ready && !clear.
REQ-019 SHALL write an accepted beat to RAM[count], element j at bits [IN_WIDTH*j +: IN_WIDTH].
REQ-020 SHALL increment count by 1 on each accepted beat.
REQ-021 SHALL, on the accepted beat with count == IN_DEPTH-1, write that beat and then set state FULL, done 1 and count IN_DEPTH on the next edge.
REQ-022 SHALL, in FULL, hold count, done and RAM contents; data_in_valid is ignored.
REQ-023 SHALL, on clear in either state, set state FILL, count 0 and done 0 on the next edge; a beat presented in the same cycle is not written; RAM contents are not erased.
REQ-024 SHALL give the read port 2-cycle latency: when ce0 = 1, stage0 <= RAM[address0] and stage1 <= stage0; q0 = stage1; both stages hold when ce0 = 0.
REQ-025 SHALL allow reads in either state, with no arbitration against writes.
REQ-026 SHALL, for a read and a write to the same address in the same cycle, return the old contents.
REQ-027 SHALL load zero into stage0 when address0 >= IN_DEPTH.
REQ-028 SHALL never let count exceed IN_DEPTH and SHALL have no wrap path other than clear or rst.

Reset
REQ-029 SHALL, on rst, set state FILL, count 0, done 0 and stage0/stage1 (and therefore q0) to 0.
REQ-030 SHALL give rst priority over clear, handshakes and ce0; RAM contents are not reset.
REQ-031 SHALL drop any in-flight frame on mid-frame rst; capture restarts at address 0.

Verification
REQ-032 SHALL cover full capture: IN_DEPTH=8, beats with data_in[j] = 16*b + j, valid held high -> ready is 1 for 8 accepted cycles; done=1 and count=8 on the next edge; ready=0 thereafter.
REQ-033 SHALL cover backpressure gaps: valid toggled 1,0,1,0 -> count increments only on valid cycles; after 8 accepted beats RAM[3] element 5 equals 0x0035.
REQ-034 SHALL cover readback latency: ce0=1, address0 = 0,1,2 on consecutive cycles -> q0 shows RAM[0], RAM[1], RAM[2] on cycles +2, +3, +4; ce0=0 freezes q0.
REQ-035 SHALL cover out-of-range read: address0=9 with ce0=1 -> q0 = 0 two cycles later.
REQ-036 SHALL cover clear with a simultaneous beat: at count=5 assert clear with valid=1 -> beat not written, count=0, done=0; the next accepted beat lands at RAM[0].
REQ-037 SHALL cover mid-frame reset: rst at count=3 -> count=0, q0=0, ready=1 after release; a new 8-beat frame sets done=1 again.

Source files
------------

// File: rtl/seq_blocks_0_result_sink.sv
// Frame capture sink: stores IN_DEPTH beats into a RAM, then holds the frame
// until clear; an independent 2-stage pipelined read port serves q0.
module seq_blocks_0_result_sink #(
  parameter int IN_SIZE    = 32,
  parameter int IN_WIDTH   = 16,
  parameter int IN_DEPTH   = 8,
  parameter int ADDR_WIDTH = $clog2(IN_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_WIDTH-1:0]          data_in [IN_SIZE],
  input  logic                         data_in_valid,
  output logic                         data_in_ready,
  input  logic                         clear,
  input  logic [ADDR_WIDTH-1:0]        address0,
  input  logic                         ce0,
  output logic [IN_WIDTH*IN_SIZE-1:0]  q0,
  output logic                         done,
  output logic [ADDR_WIDTH-1:0]        count
);

  localparam int BEAT_W = IN_WIDTH * IN_SIZE;
  localparam int IDX_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(IN_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(IN_DEPTH);

  typedef enum logic {
    FILL,
    FULL
  } state_t;

  state_t              state;
  logic [BEAT_W-1:0]   ram [IN_DEPTH];
  logic [BEAT_W-1:0]   beat;
  logic [BEAT_W-1:0]   rd_word;
  logic [BEAT_W-1:0]   stage0;
  logic [BEAT_W-1:0]   stage1;
  logic                accept;
  logic                rd_in_range;

  always_comb begin
    beat = '0;
    for (int unsigned j = 0; j < IN_SIZE; j++) begin
      beat[IN_WIDTH*j +: IN_WIDTH] = data_in[j];
    end
  end

  assign data_in_ready = (state == FILL);
  assign accept        = data_in_valid && data_in_ready && !clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      count <= '0;
      done  <= 1'b0;
    end else if (clear) begin
      state <= FILL;
      count <= '0;
      done  <= 1'b0;
    end else if (accept) begin
      count <= count + ADDR_WIDTH'(1);
      if (count == LAST_BEAT) begin
        state <= FULL;
        done  <= 1'b1;
      end
    end
  end

  // count stays below IN_DEPTH while FILL, so its low bits address the RAM directly.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      ram[count[IDX_W-1:0]] <= beat;
    end
  end

  assign rd_in_range = (address0 < DEPTH_A);

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = ram[address0[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage0 <= '0;
      stage1 <= '0;
    end else if (ce0) begin
      stage0 <= rd_word;
      stage1 <= stage0;
    end
  end

  assign q0 = stage1;

  a_count_bounded: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_A);
  a_done_matches_state: assert property (@(posedge clk) disable iff (rst) done == (state == FULL));

endmodule

// File: tb/tb_seq_blocks_0_result_sink.sv
// Randomized and directed bench for seq_blocks_0_result_sink against a
// behavioural frame/readback model.
module tb_seq_blocks_0_result_sink;

  localparam int SZ = 32;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AW = 4;
  localparam int BW = SZ * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  data_in [SZ];
  logic          data_in_valid = 1'b0;
  logic          data_in_ready;
  logic          clear = 1'b0;
  logic [AW-1:0] address0 = '0;
  logic          ce0 = 1'b0;
  logic [BW-1:0] q0;
  logic          done;
  logic [AW-1:0] count;

  seq_blocks_0_result_sink #(
    .IN_SIZE   (SZ),
    .IN_WIDTH  (W),
    .IN_DEPTH  (D),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .clear        (clear),
    .address0     (address0),
    .ce0          (ce0),
    .q0           (q0),
    .done         (done),
    .count        (count)
  );

  always #5 clk = ~clk;

  // Reference model: frame contents, fill level and the two read-pipeline slots.
  logic [BW-1:0] mem [D];
  bit            mem_known [D];
  int            m_count = 0;
  logic [BW-1:0] s0 = '0;
  logic [BW-1:0] s1 = '0;
  bit            s0_k = 1'b0;
  bit            s1_k = 1'b0;
  bit            armed = 1'b0;
  logic [BW-1:0] beat = '0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] pat(input int b, input int base);
    logic [BW-1:0] p;
    p = '0;
    for (int j = 0; j < SZ; j++) p[W*j +: W] = W'(base + 16*b + j);
    return p;
  endfunction

  task automatic tick();
    int a;
    for (int j = 0; j < SZ; j++) data_in[j] = beat[W*j +: W];
    if (armed) check("ready", BW'(data_in_ready), BW'(m_count < D));
    a = int'(address0);
    if (rst) begin
      m_count = 0;
      s0 = '0; s1 = '0; s0_k = 1'b1; s1_k = 1'b1;
    end else begin
      if (ce0) begin
        s1 = s0; s1_k = s0_k;
        if (a < D) begin
          s0 = mem[a]; s0_k = mem_known[a];
        end else begin
          s0 = '0; s0_k = 1'b1;
        end
      end
      if (clear) m_count = 0;
      else if (data_in_valid && m_count < D) begin
        mem[m_count] = beat;
        mem_known[m_count] = 1'b1;
        m_count++;
      end
    end
    @(posedge clk);
    #1;
    if (rst) armed = 1'b1;
    if (armed) begin
      check("count", BW'(count), BW'(m_count));
      check("done", BW'(done), BW'(m_count == D));
      if (s1_k) check("q0", q0, s1);
    end
  endtask

  task automatic cyc(input bit v, input bit clr, input bit r, input bit ce, input int a);
    data_in_valid = v;
    clear = clr;
    rst = r;
    ce0 = ce;
    address0 = AW'(a);
    tick();
  endtask

  initial begin
    int b;
    int k;
    logic [W-1:0] elem;
    for (int i = 0; i < D; i++) begin
      mem[i] = '0;
      mem_known[i] = 1'b0;
    end
    for (int j = 0; j < SZ; j++) data_in[j] = '0;
    #2;

    cyc(0, 0, 1, 0, 0);
    check("rst_count", BW'(count), '0);
    check("rst_q0", q0, '0);
    check("rst_ready", BW'(data_in_ready), BW'(1));

    // full capture with valid held high
    for (int i = 0; i < D; i++) begin
      beat = pat(i, 0);
      cyc(1, 0, 0, 0, 0);
    end
    check("full_done", BW'(done), BW'(1));
    check("full_count", BW'(count), BW'(D));
    beat = pat(9, 'h700);
    cyc(1, 0, 0, 0, 0);
    check("full_ready", BW'(data_in_ready), '0);
    check("full_hold", BW'(count), BW'(D));

    // backpressure gaps
    cyc(0, 1, 0, 0, 0);
    b = 0; k = 0;
    while (b < D && k < 40) begin
      beat = pat(b, 0);
      cyc(k % 2 == 0, 0, 0, 0, 0);
      if (k % 2 == 0) b++;
      k++;
    end
    check("gap_count", BW'(count), BW'(D));
    cyc(0, 0, 0, 1, 3);
    cyc(0, 0, 0, 1, 3);
    elem = q0[5*W +: W];
    check("ram3_e5", BW'(elem), BW'(16'h0035));

    // readback latency and freeze
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    check("rd_lat0", q0, mem[0]);
    cyc(0, 0, 0, 1, 2);
    check("rd_lat1", q0, mem[1]);
    cyc(0, 0, 0, 1, 2);
    check("rd_lat2", q0, mem[2]);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 5);
    check("rd_freeze", q0, mem[2]);

    // out-of-range read
    cyc(0, 0, 0, 1, 9);
    cyc(0, 0, 0, 1, 9);
    check("rd_oor", q0, '0);

    // clear with a simultaneous beat
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      beat = pat(i, 'h200);
      cyc(1, 0, 0, 0, 0);
    end
    check("clr_pre", BW'(count), BW'(5));
    beat = pat(0, 'h300);
    cyc(1, 1, 0, 0, 0);
    check("clr_count", BW'(count), '0);
    check("clr_done", BW'(done), '0);
    beat = pat(0, 'h400);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 5);
    check("clr_ram0", q0, pat(0, 'h400));
    cyc(0, 0, 0, 1, 5);
    check("clr_ram5_old", q0, pat(5, 0));

    // mid-frame reset
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      beat = pat(i, 'h500);
      cyc(1, 0, 0, 0, 0);
    end
    check("mid_pre", BW'(count), BW'(3));
    cyc(1, 0, 1, 1, 1);
    check("mid_count", BW'(count), '0);
    check("mid_q0", q0, '0);
    check("mid_ready", BW'(data_in_ready), BW'(1));
    for (int i = 0; i < D; i++) begin
      beat = pat(i, 'h600);
      cyc(1, 0, 0, 0, 0);
    end
    check("mid_done", BW'(done), BW'(1));

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < BW / 32; c++) beat[32*c +: 32] = $urandom;
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
